// File: rtl/a2b_frame_ctrl.sv
// rtl/a2b_frame_ctrl.sv - ASCII '0'/'1' character framer feeding a WORD_W-bit valid/ready word output
// Optional feature macro: A2B_ECHO_EN (echo of accepted characters to a transmitter).
module a2b_frame_ctrl #(
  parameter int WORD_W  = 8,
  parameter int TIMEOUT = 1000
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [7:0]                    in,
  input  logic                          w_RX_dv,
  output logic [WORD_W-1:0]             word_data,
  output logic                          word_valid,
  input  logic                          word_ready,
  output logic                          busy,
  output logic [$clog2(WORD_W+1)-1:0]   bit_cnt,
  output logic                          err_char,
  output logic                          err_abort,
  output logic                          overrun
`ifdef A2B_ECHO_EN
  ,
  output logic [7:0]                    echo_data,
  output logic                          echo_start,
  input  logic                          echo_busy
`endif
);

  localparam int BW = $clog2(WORD_W+1);
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT+1) : 1;
  localparam logic [TW-1:0] TLIM = (TIMEOUT > 0) ? TW'(TIMEOUT-1) : '0;
  localparam logic [BW-1:0] LAST = BW'(WORD_W-1);

  typedef enum logic [1:0] {IDLE, COLLECT, OUTPUT} state_t;

  state_t            state;
  logic [WORD_W-1:0] shift;
  logic [TW-1:0]     tcnt;

  logic              is_bit, is_space, is_term, is_illegal;
  logic              timed_out, dropped;
  logic [WORD_W-1:0] shift_nxt;

  assign is_bit     = w_RX_dv && (in[7:1] == 7'b0011000);
  assign is_space   = w_RX_dv && (in == 8'h20);
  assign is_term    = w_RX_dv && ((in == 8'h0D) || (in == 8'h0A));
  assign is_illegal = w_RX_dv && !is_bit && !is_space && !is_term;
  assign shift_nxt  = {shift[WORD_W-2:0], in[0]};
  // >= rather than == so a SPACE landing on the limit cycle only defers the abort by one cycle
  assign timed_out  = (TIMEOUT != 0) && !w_RX_dv && (tcnt >= TLIM);
  assign dropped    = (state == OUTPUT) && !word_ready;
  assign busy       = (state != IDLE);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      shift      <= '0;
      tcnt       <= '0;
      word_data  <= '0;
      word_valid <= 1'b0;
      bit_cnt    <= '0;
      err_char   <= 1'b0;
      err_abort  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      err_char  <= 1'b0;
      err_abort <= 1'b0;
      overrun   <= 1'b0;
      case (state)
        IDLE, OUTPUT: begin
          if (dropped) begin
            if (w_RX_dv) overrun <= 1'b1;
          end else begin
            // Handshake and a new character in the same cycle: treat the character as seen in IDLE
            word_valid <= 1'b0;
            state      <= IDLE;
            if (is_bit) begin
              shift   <= shift_nxt;
              bit_cnt <= BW'(1);
              tcnt    <= '0;
              state   <= COLLECT;
            end else if (is_illegal) begin
              err_char <= 1'b1;
            end
          end
        end
        COLLECT: begin
          if (is_bit) begin
            tcnt <= '0;
            if (bit_cnt == LAST) begin
              word_data  <= shift_nxt;
              word_valid <= 1'b1;
              bit_cnt    <= '0;
              shift      <= '0;
              state      <= OUTPUT;
            end else begin
              shift   <= shift_nxt;
              bit_cnt <= bit_cnt + 1'b1;
            end
          end else if (is_term || timed_out || is_illegal) begin
            err_abort <= !is_illegal;
            err_char  <= is_illegal;
            shift     <= '0;
            bit_cnt   <= '0;
            tcnt      <= '0;
            state     <= IDLE;
          end else if (TIMEOUT != 0) begin
            tcnt <= tcnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef A2B_ECHO_EN
  always_ff @(posedge clk) begin
    if (!rst) begin
      echo_data  <= '0;
      echo_start <= 1'b0;
    end else begin
      echo_start <= 1'b0;
      if (w_RX_dv && !dropped && !echo_busy) begin
        echo_data  <= in;
        echo_start <= 1'b1;
      end
    end
  end
`endif

endmodule
